ps2_zx_keyboard: RTL

- Upstream feeder of the I/O port decoder. Turns a PS/2 set-2 keyboard stream into the 8x5 ZX Spectrum key matrix.
- Answers half-row scans with the 5-bit active-low `kd` vector read through port #FE.
- Also produces the magic-button level, a keyboard reset request and, optionally, a Kempston joystick vector from the numeric keypad.

---
 rtl/ps2_zx_keyboard_if.sv | 22 ++
 rtl/ps2_zx_keyboard.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_zx_keyboard_if.sv
// Bus between the PS/2 keyboard front end and its consumers: raw PS/2 lines,
// half-row select, and the matrix/status outputs.
interface ps2_zx_keyboard_if;
    logic       ps2_clk;
    logic       ps2_dat;
    logic [7:0] addr_hi;
    logic [4:0] kd;
    logic       magic_button;
    logic       kbd_reset;
    logic       rx_error;
    logic [4:0] joy_out;

    modport master (
        output ps2_clk, ps2_dat, addr_hi,
        input  kd, magic_button, kbd_reset, rx_error, joy_out
    );

    modport slave (
        input  ps2_clk, ps2_dat, addr_hi,
        output kd, magic_button, kbd_reset, rx_error, joy_out
    );
endinterface

// File: rtl/ps2_zx_keyboard.sv
// PS/2 set-2 keyboard to ZX Spectrum 8x5 matrix, answering #FE half-row scans.
// Optional macro PS2_NUMPAD_JOY_EN: numeric keypad drives the Kempston joy_out.
module ps2_zx_keyboard #(
    parameter int unsigned FILTER_LEN     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 28000
) (
    input logic               clk28,
    input logic               rst,
    ps2_zx_keyboard_if.slave  bus
);
    localparam int unsigned FW = $clog2(FILTER_LEN + 1);
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

    // Indices into the composite/special key flag vector
    localparam int unsigned F_LSH = 0, F_RSH = 1, F_CTRL = 2, F_ALT = 3,
                            F_DEL = 4, F_F12 = 5, F_BS = 6, F_LEFT = 7,
                            F_DOWN = 8, F_UP = 9, F_RIGHT = 10;

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

    logic [1:0]      r_clk_s, r_dat_s;
    logic [FW-1:0]   r_flt_cnt;
    logic            r_clk_f, r_fall, r_fall_dat;
    state_t          r_state;
    logic [2:0]      r_bitcnt;
    logic [7:0]      r_shift;
    logic            r_par_ok, r_byte_vld, r_rx_error;
    logic [TW-1:0]   r_to_cnt;
    logic            r_ext, r_rel;
    logic [7:0][4:0] r_key;
    logic [10:0]     r_flg;
    logic [4:0]      r_kd;
    logic            r_magic, r_kbd_reset;
    logic [6:0]      w_key;
    logic [4:0]      w_sp;
    logic [7:0][4:0] w_mat;
    logic [4:0]      w_sel;

    // {valid, row, col} for keys that occupy a plain matrix position
    function automatic logic [6:0] f_lookup(input logic [7:0] c);
        case (c)
            8'h1A: return {1'b1, 3'd0, 3'd1};  8'h22: return {1'b1, 3'd0, 3'd2};
            8'h21: return {1'b1, 3'd0, 3'd3};  8'h2A: return {1'b1, 3'd0, 3'd4};
            8'h1C: return {1'b1, 3'd1, 3'd0};  8'h1B: return {1'b1, 3'd1, 3'd1};
            8'h23: return {1'b1, 3'd1, 3'd2};  8'h2B: return {1'b1, 3'd1, 3'd3};
            8'h34: return {1'b1, 3'd1, 3'd4};  8'h15: return {1'b1, 3'd2, 3'd0};
            8'h1D: return {1'b1, 3'd2, 3'd1};  8'h24: return {1'b1, 3'd2, 3'd2};
            8'h2D: return {1'b1, 3'd2, 3'd3};  8'h2C: return {1'b1, 3'd2, 3'd4};
            8'h16: return {1'b1, 3'd3, 3'd0};  8'h1E: return {1'b1, 3'd3, 3'd1};
            8'h26: return {1'b1, 3'd3, 3'd2};  8'h25: return {1'b1, 3'd3, 3'd3};
            8'h2E: return {1'b1, 3'd3, 3'd4};  8'h45: return {1'b1, 3'd4, 3'd0};
            8'h46: return {1'b1, 3'd4, 3'd1};  8'h3E: return {1'b1, 3'd4, 3'd2};
            8'h3D: return {1'b1, 3'd4, 3'd3};  8'h36: return {1'b1, 3'd4, 3'd4};
            8'h4D: return {1'b1, 3'd5, 3'd0};  8'h44: return {1'b1, 3'd5, 3'd1};
            8'h43: return {1'b1, 3'd5, 3'd2};  8'h3C: return {1'b1, 3'd5, 3'd3};
            8'h35: return {1'b1, 3'd5, 3'd4};  8'h5A: return {1'b1, 3'd6, 3'd0};
            8'h4B: return {1'b1, 3'd6, 3'd1};  8'h42: return {1'b1, 3'd6, 3'd2};
            8'h3B: return {1'b1, 3'd6, 3'd3};  8'h33: return {1'b1, 3'd6, 3'd4};
            8'h29: return {1'b1, 3'd7, 3'd0};  8'h3A: return {1'b1, 3'd7, 3'd2};
            8'h31: return {1'b1, 3'd7, 3'd3};  8'h32: return {1'b1, 3'd7, 3'd4};
            default: return 7'd0;
        endcase
    endfunction

    // {valid, flag index} for shifts, modifiers and composite keys
    function automatic logic [4:0] f_special(input logic [8:0] c);
        case (c)
            9'h012: return {1'b1, 4'(F_LSH)};
            9'h059: return {1'b1, 4'(F_RSH)};
            9'h014: return {1'b1, 4'(F_CTRL)};
            9'h011: return {1'b1, 4'(F_ALT)};
            9'h171: return {1'b1, 4'(F_DEL)};
            9'h007: return {1'b1, 4'(F_F12)};
            9'h066: return {1'b1, 4'(F_BS)};
            9'h16B: return {1'b1, 4'(F_LEFT)};
            9'h172: return {1'b1, 4'(F_DOWN)};
            9'h175: return {1'b1, 4'(F_UP)};
            9'h174: return {1'b1, 4'(F_RIGHT)};
            default: return 5'd0;
        endcase
    endfunction

`ifdef PS2_NUMPAD_JOY_EN
    logic [4:0] r_joy;
    logic [3:0] w_joy;

    function automatic logic [3:0] f_joy(input logic [8:0] c);
        case (c)
            9'h074: return {1'b1, 3'd0};
            9'h06B: return {1'b1, 3'd1};
            9'h072: return {1'b1, 3'd2};
            9'h075: return {1'b1, 3'd3};
            9'h073: return {1'b1, 3'd4};
            default: return 4'd0;
        endcase
    endfunction

    assign w_joy       = f_joy({r_ext, r_shift});
    assign bus.joy_out = r_joy;
`else
    assign bus.joy_out = 5'd0;
`endif

    assign w_key = r_ext ? 7'd0 : f_lookup(r_shift);
    assign w_sp  = f_special({r_ext, r_shift});

    // Synchronise, glitch-filter the PS/2 clock and strobe its falling edge
    always_ff @(posedge clk28) begin
        if (rst) begin
            r_clk_s    <= 2'b11;
            r_dat_s    <= 2'b11;
            r_flt_cnt  <= '0;
            r_clk_f    <= 1'b1;
            r_fall     <= 1'b0;
            r_fall_dat <= 1'b1;
        end else begin
            r_clk_s <= {r_clk_s[0], bus.ps2_clk};
            r_dat_s <= {r_dat_s[0], bus.ps2_dat};
            r_fall  <= 1'b0;
            if (r_clk_s[1] == r_clk_f) begin
                r_flt_cnt <= '0;
            end else if (r_flt_cnt == FW'(FILTER_LEN - 1)) begin
                r_flt_cnt  <= '0;
                r_clk_f    <= r_clk_s[1];
                r_fall     <= r_clk_f;
                r_fall_dat <= r_dat_s[1];
            end else begin
                r_flt_cnt <= r_flt_cnt + FW'(1);
            end
        end
    end

    // Frame receiver with inter-edge timeout
    always_ff @(posedge clk28) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_bitcnt   <= '0;
            r_shift    <= '0;
            r_par_ok   <= 1'b0;
            r_to_cnt   <= '0;
            r_byte_vld <= 1'b0;
            r_rx_error <= 1'b0;
        end else begin
            r_byte_vld <= 1'b0;
            r_rx_error <= 1'b0;
            if (r_fall) begin
                r_to_cnt <= '0;
                case (r_state)
                    S_IDLE: if (!r_fall_dat) begin
                        r_state  <= S_DATA;
                        r_bitcnt <= '0;
                    end
                    S_DATA: begin
                        r_shift  <= {r_fall_dat, r_shift[7:1]};
                        r_bitcnt <= r_bitcnt + 3'd1;
                        if (r_bitcnt == 3'd7) r_state <= S_PARITY;
                    end
                    S_PARITY: begin
                        r_par_ok <= ^{r_shift, r_fall_dat};
                        r_state  <= S_STOP;
                    end
                    S_STOP: begin
                        if (r_fall_dat && r_par_ok) r_byte_vld <= 1'b1;
                        else                        r_rx_error <= 1'b1;
                        r_state <= S_IDLE;
                    end
                    default: r_state <= S_IDLE;
                endcase
            end else if (r_state != S_IDLE) begin
                if (r_to_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                    r_state    <= S_IDLE;
                    r_rx_error <= 1'b1;
                    r_to_cnt   <= '0;
                end else begin
                    r_to_cnt <= r_to_cnt + TW'(1);
                end
            end
        end
    end

    // Scan-code decoder; r_shift holds the byte while r_byte_vld is high
    always_ff @(posedge clk28) begin
        if (rst) begin
            r_ext <= 1'b0;
            r_rel <= 1'b0;
            r_key <= '0;
            r_flg <= '0;
`ifdef PS2_NUMPAD_JOY_EN
            r_joy <= '0;
`endif
        end else if (r_byte_vld) begin
            case (r_shift)
                8'hE0: r_ext <= 1'b1;
                8'hF0: r_rel <= 1'b1;
                8'hAA, 8'hFA, 8'hEE, 8'hFE: ;
                8'h00, 8'hFF: begin
                    r_ext <= 1'b0;
                    r_rel <= 1'b0;
                    r_key <= '0;
                    r_flg <= '0;
`ifdef PS2_NUMPAD_JOY_EN
                    r_joy <= '0;
`endif
                end
                default: begin
                    r_ext <= 1'b0;
                    r_rel <= 1'b0;
                    if (w_key[6]) r_key[w_key[5:3]][w_key[2:0]] <= !r_rel;
                    if (w_sp[4])  r_flg[w_sp[3:0]] <= !r_rel;
`ifdef PS2_NUMPAD_JOY_EN
                    if (w_joy[3]) r_joy[w_joy[2:0]] <= !r_rel;
`endif
                end
            endcase
        end
    end

    // Composite keys are ORed in so they never cancel a physical press
    always_comb begin
        w_mat       = r_key;
        w_mat[0][0] = r_flg[F_LSH] | r_flg[F_RSH] | r_flg[F_BS] | r_flg[F_LEFT]
                    | r_flg[F_DOWN] | r_flg[F_UP] | r_flg[F_RIGHT];
        w_mat[3][4] = r_key[3][4] | r_flg[F_LEFT];
        w_mat[4][0] = r_key[4][0] | r_flg[F_BS];
        w_mat[4][4] = r_key[4][4] | r_flg[F_DOWN];
        w_mat[4][3] = r_key[4][3] | r_flg[F_UP];
        w_mat[4][2] = r_key[4][2] | r_flg[F_RIGHT];
        w_mat[7][1] = r_flg[F_CTRL];
        w_sel       = 5'd0;
        for (int r = 0; r < 8; r++) begin
            if (!bus.addr_hi[r]) w_sel = w_sel | w_mat[r];
        end
    end

    always_ff @(posedge clk28) begin
        if (rst) begin
            r_kd        <= 5'b11111;
            r_magic     <= 1'b0;
            r_kbd_reset <= 1'b0;
        end else begin
            r_kd        <= ~w_sel;
            r_magic     <= r_flg[F_F12];
            r_kbd_reset <= r_flg[F_CTRL] & r_flg[F_ALT] & r_flg[F_DEL];
        end
    end

    assign bus.kd           = r_kd;
    assign bus.magic_button = r_magic;
    assign bus.kbd_reset    = r_kbd_reset;
    assign bus.rx_error     = r_rx_error;
endmodule
